// File: rtl/fifo_word_reader.sv
// Byte FIFO read-side consumer: pops bytes with a one-cycle read latency,
// packs BYTES of them little-endian into a word and offers it on valid/ready.
module fifo_word_reader_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module fifo_word_reader #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    empty,
    input  logic [DATA_W-1:0]       dout,
    output logic                    rd,
    output logic [DATA_W*BYTES-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CNT_W-1:0]        word_count
);
    localparam int            CW       = $clog2(BYTES + 1);
    localparam logic [CW:0]   LVL_LAST = (CW+1)'(BYTES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);

    logic [CW-1:0]                cnt;
    logic                         pend;
    logic [CW:0]                  level;
    logic                         out_free;
    logic                         accept;
    logic                         last_byte;
    logic [BYTES-2:0][DATA_W-1:0] lanes;

    // bytes already captured plus the one still in flight from the FIFO
    assign level     = {1'b0, cnt} + {{CW{1'b0}}, pend};
    assign out_free  = !m_valid || m_ready;
    assign accept    = m_valid && m_ready;
    assign last_byte = pend && (cnt == CNT_LAST);

    // The final byte of a word is only requested once the output register is
    // guaranteed free at its capture edge, so a completed word never overwrites.
    assign rd = !rst && !empty &&
                ((level < LVL_LAST) || ((level == LVL_LAST) && out_free));

    // The top lane is never stored: it goes straight from dout into m_data.
    for (genvar i = 0; i < BYTES - 1; i++) begin : g_lane
        fifo_word_reader_lane #(.DATA_W(DATA_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (pend && (cnt == CW'(i))),
            .d   (dout),
            .q   (lanes[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            pend       <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            word_count <= '0;
        end else begin
            pend <= rd;
            if (accept) word_count <= word_count + CNT_W'(1);
            if (last_byte) begin
                m_data  <= {dout, lanes};
                m_valid <= 1'b1;
                cnt     <= '0;
            end else begin
                if (pend)   cnt     <= cnt + CW'(1);
                if (accept) m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: behavioural byte FIFO, word scoreboard filled as
// bytes are pushed and drained as the DUT hands words downstream.
module tb_fifo_word_reader;
    localparam int DATA_W = 8;
    localparam int BYTES  = 4;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    empty;
    logic [DATA_W-1:0]       dout;
    logic                    rd;
    logic [DATA_W*BYTES-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [CNT_W-1:0]        word_count;

    fifo_word_reader #(.DATA_W(DATA_W), .BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .dout       (dout),
        .rd         (rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int                      n_chk = 0;
    int                      n_err = 0;
    int                      cyc = 0;
    int                      rd_cycles = 0;
    int                      rd_run = 0;
    int                      max_run = 0;
    logic [DATA_W-1:0]       fifo_q[$];
    logic [DATA_W*BYTES-1:0] exp_q[$];
    int                      acc_t[$];
    logic [DATA_W*BYTES-1:0] acc;
    int                      nb = 0;
    logic [CNT_W-1:0]        exp_wc = '0;
    logic                    hold = 1'b0;
    logic [DATA_W*BYTES-1:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        fifo_q.push_back(b);
        acc[nb*DATA_W +: DATA_W] = b;
        nb++;
        if (nb == BYTES) begin
            exp_q.push_back(acc);
            nb = 0;
        end
    endtask

    // One cycle: observe at negedge, service the FIFO at posedge, drive after.
    task automatic tick();
        logic [DATA_W*BYTES-1:0] e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (empty) chk("rd_when_empty", rd, 1'b0);
            if (rd) begin
                rd_cycles++;
                rd_run++;
                if (rd_run > max_run) max_run = rd_run;
            end else rd_run = 0;
            if (m_valid) begin
                if (hold) chk("hold_stable", m_data, held);
                if (m_ready) begin
                    if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("word", m_data, e);
                    end
                    exp_wc++;
                    acc_t.push_back(cyc);
                    hold = 1'b0;
                end else begin
                    held = m_data;
                    hold = 1'b1;
                end
            end else begin
                if (hold) chk("valid_dropped", m_valid, 1'b1);
                hold = 1'b0;
            end
        end
        @(posedge clk);
        if (rd) begin
            if (fifo_q.size() == 0) chk("fifo_underflow", fifo_q.size(), 1);
            else dout <= fifo_q.pop_front();
        end
        empty <= (fifo_q.size() == 0);
        #1;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid) break;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("drain", exp_q.size() + fifo_q.size(), 0);
        m_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        nb = 0;
        hold = 1'b0;
        tick();
        tick();
        exp_wc = '0;
    endtask

    int base;

    initial begin
        empty = 1'b1;
        dout = '0;
        m_ready = 1'b1;
        rst = 1'b1;
        do_reset();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_rd", rd, 1'b0);
        rst = 1'b0;
        tick();

        // single word
        base = rd_cycles; max_run = 0;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_done(40, 0);
        chk("t1_rd_cycles", rd_cycles - base, 4);
        chk("t1_rd_run", max_run, 4);
        chk("t1_word_count", word_count, exp_wc);
        chk("t1_wc_one", word_count, 1);

        // streaming 12 bytes
        base = rd_cycles; acc_t.delete();
        for (int i = 0; i < 12; i++) push_byte(8'(i));
        wait_done(80, 0);
        chk("t2_rd_cycles", rd_cycles - base, 12);
        chk("t2_words", acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            chk("t2_gap0", (acc_t[1] - acc_t[0]) <= BYTES + 1, 1);
            chk("t2_gap1", (acc_t[2] - acc_t[1]) <= BYTES + 1, 1);
        end
        chk("t2_word_count", word_count, exp_wc);

        // output stall
        m_ready = 1'b0;
        base = rd_cycles;
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        repeat (15) tick();
        chk("t3_stall_valid", m_valid, 1'b1);
        chk("t3_stall_rds", rd_cycles - base, 7);
        chk("t3_stall_data", m_data, 32'h33323130);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (4) tick();
        chk("t3_second_valid", m_valid, 1'b1);
        chk("t3_total_rds", rd_cycles - base, 8);
        m_ready = 1'b1;
        wait_done(20, 0);
        chk("t3_word_count", word_count, exp_wc);

        // FIFO runs dry mid-word
        push_byte(8'hAA); push_byte(8'hBB);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_gap_valid", m_valid, 1'b0);
        end
        push_byte(8'hCC); push_byte(8'hDD);
        wait_done(20, 0);
        chk("t4_word_count", word_count, exp_wc);

        // reset with a byte in flight and two captured
        base = rd_cycles;
        push_byte(8'h50); push_byte(8'h51); push_byte(8'h52);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_cycles - base >= 3) break;
        end
        chk("t5_reads_before_rst", rd_cycles - base, 3);
        rst = 1'b1;
        fifo_q.delete(); exp_q.delete(); nb = 0; hold = 1'b0;
        tick();
        chk("t5_rst_valid", m_valid, 1'b0);
        chk("t5_rst_rd", rd, 1'b0);
        chk("t5_rst_wc", word_count, 0);
        exp_wc = '0;
        rst = 1'b0;
        push_byte(8'h60); push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
        wait_done(30, 0);
        chk("t5_word_count", word_count, exp_wc);

        // random backpressure
        for (int i = 0; i < 32; i++) push_byte(8'($urandom));
        wait_done(400, 1);
        chk("t6_word_count", word_count, exp_wc);

        // counter wrap over 17 words
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 17 * BYTES; i++) push_byte(8'(i * 3));
        wait_done(200, 0);
        chk("t7_wrap", word_count, 1);
        chk("t7_word_count", word_count, exp_wc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Read-side consumer for the team's 8-bit synchronous FIFO.
- Drives the FIFO `rd` strobe, captures `dout`, packs BYTES consecutive bytes into one word and presents it on a valid/ready output stream.
- Sits between the byte FIFO and any word-wide downstream block.
- Pairs with the FIFO write-side driver as the opposite end of the same wr/rd/din/dout/empty/full protocol.

Parameters:
- DATA_W, 8: FIFO byte width; must match the FIFO `dout` width.
- BYTES, 4: bytes packed per output word; legal range 2..8.
- CNT_W, 16: width of the completed-word statistics counter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag; sampled combinationally in the same cycle as `rd`.
- dout  input  DATA_W  FIFO read data; valid in the cycle after the edge that sampled `rd`=1.
- rd  output  1  FIFO pop strobe; combinational from state and `empty`.
- m_data  output  DATA_W*BYTES  packed word.
- m_valid  output  1  `m_data` holds an unconsumed word.
- m_ready  input  1  downstream accepts the word when `m_valid` and `m_ready` are both 1 at a rising edge.
- word_count  output  CNT_W  number of words accepted downstream.

Behaviour:
- Interface clocking: one clock, `clk`; reset `rst` is synchronous and active-high. No other clock or reset.
- Reset values:
  - `m_valid`=0, `m_data`=0, `word_count`=0.
  - Internal byte count `cnt`=0, pending flag `pend`=0.
  - `rd`=0 while `rst`=1.
- FIFO read latency is 1 cycle:
  - `rd`=1 sampled at edge E sets `pend`=1 at E.
  - At edge E+1, `dout` is written into byte lane `cnt` of the assembly register; `cnt` increments.
  - At most one byte is in flight.
  - `pend` at E+1 equals the `rd` value sampled at E, so back-to-back reads give 1 byte/cycle.
- Define `out_free` = !`m_valid` || `m_ready`.
- Pop rule: `rd` = !`rst` && !`empty` && ( (`cnt`+`pend` < BYTES-1) || (`cnt`+`pend` == BYTES-1 && `out_free`) ).
  - `rd` is never 1 when `empty`=1.
  - `rd` is never 1 when `cnt`+`pend` == BYTES.
- Byte order is little-endian: the first popped byte lands in `m_data[DATA_W-1:0]`, the last in the top lane.
- Word completion: when the captured byte makes `cnt` reach BYTES, at that same edge:
  - the assembly register plus the new byte load into `m_data`;
  - `m_valid`=1 and `cnt`=0.
  - The pop rule guarantees the output register is free at that edge, so no word is overwritten.
- Output handshake:
  - `m_data` is stable while `m_valid`=1 && !`m_ready`.
  - On accept, `m_valid` clears unless a new word completes at the same edge; in that case `m_valid` stays 1 and `m_data` takes the new word.
  - Throughput is 1 word per BYTES cycles with `m_ready` held at 1 and the FIFO never empty.
- `word_count` increments by 1 on each accept and wraps modulo 2^CNT_W.
- Empty mid-word: partial bytes are held indefinitely; there is no timeout and no partial flush.
- Output stall: reads continue until `cnt`=BYTES-1, then `rd` holds at 0 until `out_free`.
- Reset mid-operation:
  - An in-flight byte (`pend`=1) is discarded; the FIFO entry is still consumed. This loss is accepted.
  - Partial word and output word are dropped.
- Simultaneous events (capture completing a word, accept, and a new `rd`) are all legal in one cycle.

Test Plan:
- Reset then FIFO filled with 0x11,0x22,0x33,0x44; `m_ready`=1 -> `rd` high for exactly 4 consecutive cycles; `m_valid` pulses once with `m_data`=0x44332211; `word_count`=1.
- 12 bytes 0x00..0x0B streamed, FIFO never empty, `m_ready`=1 -> words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive 4-cycle boundaries; `rd` never deasserts; `word_count`=3.
- `m_ready`=0 with 8 bytes available -> first word valid and held stable; `rd` stops after byte 7 is requested (`cnt`=3); raising `m_ready` for one cycle -> last byte captured, second word valid next; no byte lost or duplicated.
- FIFO goes empty after 2 bytes (0xAA,0xBB), refilled 10 cycles later with 0xCC,0xDD -> `m_valid` stays 0 during the gap; word = 0xDDCCBBAA; `rd`=0 whenever `empty`=1.
- `rst` asserted the cycle after a `rd`, with `cnt`=2 -> next cycle `m_valid`=0, `rd`=0, `word_count`=0; the next 4 bytes after reset form a clean word.
- CNT_W=4: 17 words accepted -> `word_count` wraps to 1.
